// File: rtl/vs_load_down_counter.sv
// Loadable N-bit down-counter / interval timer with optional auto-reload and a
// one-cycle terminal-count pulse. Optional prescaler: VS_LOAD_DOWN_COUNTER_PRESCALE_EN.
module vs_load_down_counter #(
  parameter int N        = 16,
  parameter int PRESCALE = 4
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         load,
  input  logic [N-1:0] load_value,
  input  logic         enable,
  input  logic         auto_reload,
  output logic [N-1:0] out,
  output logic         zero,
  output logic         tc,
  output logic         running
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic [N-1:0] out_q, out_d;
  logic [N-1:0] reload_q, reload_d;
  logic         tc_q, tc_d;
  logic         running_q, running_d;
  logic         step;
  logic         dec_en;

`ifdef VS_LOAD_DOWN_COUNTER_PRESCALE_EN
  localparam int PW = $clog2(PRESCALE) + 1;

  logic [PW-1:0] presc_q, presc_d;

  // step marks the PRESCALE-th enabled RUN cycle since the last wrap or load
  assign step = (presc_q == PW'(PRESCALE - 1));

  always_comb begin
    presc_d = presc_q;
    if (load) begin
      presc_d = '0;
    end else if (state_q == RUN && enable) begin
      presc_d = step ? '0 : presc_q + PW'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end
`else
  // Without the prescaler every enabled RUN cycle is a decrement; PRESCALE is inert.
  assign step = 1'b1 | (PRESCALE == 0);
`endif

  assign dec_en = (state_q == RUN) && enable && step;

  always_comb begin
    state_d  = state_q;
    out_d    = out_q;
    reload_d = reload_q;
    tc_d     = 1'b0;

    if (load) begin
      reload_d = load_value;
      out_d    = load_value;
      state_d  = (load_value != '0) ? RUN : DONE;
    end else begin
      case (state_q)
        RUN: begin
          if (out_q == '0) begin
            // Unreachable in normal use; park safely rather than wrap.
            state_d = DONE;
          end else if (dec_en) begin
            if (out_q == N'(1)) begin
              tc_d = 1'b1;
              if (auto_reload) begin
                out_d = reload_q;
              end else begin
                out_d   = '0;
                state_d = DONE;
              end
            end else begin
              out_d = out_q - N'(1);
            end
          end
        end
        DONE: begin
          out_d = '0;
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end

    running_d = (state_d == RUN);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      out_q     <= '0;
      reload_q  <= '0;
      tc_q      <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      out_q     <= out_d;
      reload_q  <= reload_d;
      tc_q      <= tc_d;
      running_q <= running_d;
    end
  end

  assign out     = out_q;
  assign zero    = (out_q == '0);
  assign tc      = tc_q;
  assign running = running_q;

endmodule

// File: tb/tb_vs_load_down_counter.sv
// Scoreboard bench for vs_load_down_counter: a behavioural model pushes the
// expected registered outputs per cycle, which are popped after each rising edge.
module tb_vs_load_down_counter;

  localparam int N        = 16;
  localparam int PRESCALE = 4;

  logic         clock;
  logic         reset_n;
  logic         load;
  logic [N-1:0] load_value;
  logic         enable;
  logic         auto_reload;
  logic [N-1:0] out;
  logic         zero;
  logic         tc;
  logic         running;

  vs_load_down_counter #(
    .N        (N),
    .PRESCALE (PRESCALE)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .load        (load),
    .load_value  (load_value),
    .enable      (enable),
    .auto_reload (auto_reload),
    .out         (out),
    .zero        (zero),
    .tc          (tc),
    .running     (running)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [N-1:0] out;
    logic         zero;
    logic         tc;
    logic         running;
  } exp_t;

  exp_t exp_q[$];

  int checks   = 0;
  int failures = 0;

  // Reference model state: 0 = idle, 1 = run, 2 = done
  int           m_state;
  logic [N-1:0] m_out;
  logic [N-1:0] m_rel;
  logic         m_tc;
  int           m_pre;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    m_out   = '0;
    m_rel   = '0;
    m_tc    = 1'b0;
    m_pre   = 0;
  endtask

  task automatic model_step(input logic ld, input logic [N-1:0] lv, input logic en, input logic ar);
    bit dec;
    exp_t e;
    m_tc = 1'b0;
    if (ld) begin
      m_rel   = lv;
      m_out   = lv;
      m_pre   = 0;
      m_state = (lv != 0) ? 1 : 2;
    end else if (m_state == 1 && en) begin
      dec = 1'b1;
`ifdef VS_LOAD_DOWN_COUNTER_PRESCALE_EN
      if (m_pre == PRESCALE - 1) m_pre = 0;
      else begin
        m_pre++;
        dec = 1'b0;
      end
`endif
      if (dec) begin
        if (m_out == 1) begin
          m_tc = 1'b1;
          if (ar) m_out = m_rel;
          else begin
            m_out   = '0;
            m_state = 2;
          end
        end else begin
          m_out = m_out - 1'b1;
        end
      end
    end
    e.out     = m_out;
    e.zero    = (m_out == 0);
    e.tc      = m_tc;
    e.running = (m_state == 1);
    exp_q.push_back(e);
  endtask

  // Drive one cycle of stimulus, predict, then compare after the rising edge.
  task automatic cycle(input logic ld, input logic [N-1:0] lv, input logic en, input logic ar);
    exp_t e;
    @(negedge clock);
    load        = ld;
    load_value  = lv;
    enable      = en;
    auto_reload = ar;
    model_step(ld, lv, en, ar);
    @(posedge clock);
    #1;
    if (exp_q.size() == 0) begin
      check_val("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check_val("out", 32'(out), 32'(e.out));
      check_val("zero", 32'(zero), 32'(e.zero));
      check_val("tc", 32'(tc), 32'(e.tc));
      check_val("running", 32'(running), 32'(e.running));
    end
  endtask

  int tc_cycle;
  logic [N-1:0] ar_seq [6];

  initial begin
    load        = 1'b0;
    load_value  = '0;
    enable      = 1'b0;
    auto_reload = 1'b0;
    reset_n     = 1'b0;
    model_reset();
    #12;
    check_val("rst_out", 32'(out), 32'd0);
    check_val("rst_zero", 32'(zero), 32'd1);
    check_val("rst_tc", 32'(tc), 32'd0);
    check_val("rst_running", 32'(running), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;

    // IDLE ignores enable and auto_reload
    for (int i = 0; i < 3; i++) cycle(1'b0, 16'd0, 1'b1, 1'b1);

    // Reset mid-count: 7 -> 6 -> 5 -> 4, then async reset between edges
    cycle(1'b1, 16'd7, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 16'd0, 1'b1, 1'b0);
    check_val("pre_reset_out", 32'(out), 32'd4);
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    check_val("async_rst_out", 32'(out), 32'd0);
    check_val("async_rst_zero", 32'(zero), 32'd1);
    check_val("async_rst_tc", 32'(tc), 32'd0);
    check_val("async_rst_running", 32'(running), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    cycle(1'b0, 16'd0, 1'b1, 1'b0);

`ifndef VS_LOAD_DOWN_COUNTER_PRESCALE_EN
    // One-shot 5..0, then idle at 0 for 10 cycles
    cycle(1'b1, 16'd5, 1'b1, 1'b0);
    for (int i = 0; i < 15; i++) cycle(1'b0, 16'd0, 1'b1, 1'b0);
    check_val("oneshot_final_out", 32'(out), 32'd0);

    // Auto-reload 3: 3,2,1,3,2,1,3
    cycle(1'b1, 16'd3, 1'b1, 1'b1);
    ar_seq = '{16'd2, 16'd1, 16'd3, 16'd2, 16'd1, 16'd3};
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, 16'd0, 1'b1, 1'b1);
      check_val("autoreload_seq", 32'(out), 32'(ar_seq[i]));
    end

    // Enable gaps: 10,9,9,8,8 then reload override with 20
    cycle(1'b1, 16'd10, 1'b1, 1'b0);
    cycle(1'b0, 16'd0, 1'b1, 1'b0);
    cycle(1'b0, 16'd0, 1'b0, 1'b0);
    cycle(1'b0, 16'd0, 1'b1, 1'b0);
    cycle(1'b0, 16'd0, 1'b0, 1'b0);
    check_val("gap_out", 32'(out), 32'd8);
    cycle(1'b1, 16'd20, 1'b1, 1'b0);
    check_val("override_out", 32'(out), 32'd20);

    // Load in the expiry cycle wins
    cycle(1'b1, 16'd2, 1'b1, 1'b1);
    cycle(1'b0, 16'd0, 1'b1, 1'b1);
    cycle(1'b1, 16'd6, 1'b1, 1'b1);
    check_val("expiry_load_out", 32'(out), 32'd6);
    check_val("expiry_load_tc", 32'(tc), 32'd0);

    // Load zero goes straight to DONE with no tc
    cycle(1'b1, 16'd0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) cycle(1'b0, 16'd0, 1'b1, 1'b1);
`else
    // Prescale: load 2, tc after 8 enabled cycles
    cycle(1'b1, 16'd2, 1'b1, 1'b0);
    tc_cycle = 0;
    for (int i = 1; i <= 12; i++) begin
      cycle(1'b0, 16'd0, 1'b1, 1'b0);
      if (tc === 1'b1) tc_cycle = i;
    end
    check_val("prescale_tc_cycle", 32'(tc_cycle), 32'd8);

    // Enable gaps hold the prescaler
    cycle(1'b1, 16'd3, 1'b1, 1'b1);
    for (int i = 0; i < 20; i++) cycle(1'b0, 16'd0, 1'(i % 3 != 0), 1'b1);
`endif

    // Randomised mix
    for (int i = 0; i < 300; i++) begin
      cycle(1'($urandom_range(0, 7) == 0), 16'($urandom_range(0, 5)),
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=%0d expected=%0d", checks, 0);
    $fatal(1, "timeout");
  end

endmodule
